// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller with a request/ack quiesce handshake.
// Optional gated-cycle statistics under CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned STAT_W      = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic busy_i,
  input  logic wake_i,
  output logic gate_req_o,
  input  logic gate_ack_i,
  input  logic test_en_i,
  output logic clk_en_o,
  output logic ready_o
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [STAT_W-1:0] gated_cycles_o
`endif
);

  localparam int unsigned MAX_C =
    (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  typedef logic [STAT_W-1:0] stat_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    GATE_REQ = 2'd1,
    GATED    = 2'd2,
    WAKE     = 2'd3
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic             idle;

  assign idle     = enable_i & ~busy_i & ~wake_i;
  assign clk_en_o = en_q | test_en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RUN;
      cnt        <= '0;
      en_q       <= 1'b1;
      ready_o    <= 1'b1;
      gate_req_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!idle) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            state      <= GATE_REQ;
            cnt        <= '0;
            ready_o    <= 1'b0;
            gate_req_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GATE_REQ: begin
          // abort wins over a same-cycle ack
          if (!idle) begin
            state      <= RUN;
            ready_o    <= 1'b1;
            gate_req_o <= 1'b0;
          end else if (gate_ack_i) begin
            state <= GATED;
            en_q  <= 1'b0;
          end
        end
        GATED: begin
          if (!idle) begin
            state      <= WAKE;
            cnt        <= '0;
            en_q       <= 1'b1;
            gate_req_o <= 1'b0;
          end
        end
        WAKE: begin
          if (cnt == WAKE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            ready_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= RUN;
          cnt        <= '0;
          en_q       <= 1'b1;
          ready_o    <= 1'b1;
          gate_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_GATE_CTRL_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gated_cycles_o <= '0;
    end else if (stats_clr_i) begin
      gated_cycles_o <= '0;
    end else if (state == GATED && gated_cycles_o != stat_t'('1)) begin
      gated_cycles_o <= gated_cycles_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Randomised and directed bench for clk_gate_ctrl against a
// behavioural model of the gating handshake.
module tb_clk_gate_ctrl;

  localparam int IDLE = 16;
  localparam int WAKE = 2;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 0;
  logic rst_n = 0;
  logic en = 0, busy = 0, wake = 0, ack = 0, ten = 0, clr = 0;
  logic clk_en, ready, req;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [SW-1:0] gc;
`endif

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .STAT_W(SW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .enable_i(en),
    .busy_i(busy),
    .wake_i(wake),
    .gate_req_o(req),
    .gate_ack_i(ack),
    .test_en_i(ten),
    .clk_en_o(clk_en),
    .ready_o(ready)
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    .stats_clr_i(clr),
    .gated_cycles_o(gc)
`endif
  );

  int errs = 0;
  int checks = 0;

  typedef enum int {M_RUN, M_REQ, M_GATED, M_WAKE} mode_e;
  mode_e m;
  int streak, wleft, gcount;

  function automatic void model_reset();
    m = M_RUN;
    streak = 0;
    wleft = 0;
    gcount = 0;
  endfunction

  function automatic void model_step();
    bit idle;
    idle = en && !busy && !wake;
    if (clr) gcount = 0;
    else if (m == M_GATED && gcount < SMAX) gcount++;
    case (m)
      M_RUN: begin
        if (!idle) streak = 0;
        else begin
          streak++;
          if (streak == IDLE) begin
            m = M_REQ;
            streak = 0;
          end
        end
      end
      M_REQ: begin
        if (!idle) m = M_RUN;
        else if (ack) m = M_GATED;
      end
      M_GATED: begin
        if (!idle) begin
          m = M_WAKE;
          wleft = WAKE;
        end
      end
      default: begin
        wleft--;
        if (wleft == 0) m = M_RUN;
      end
    endcase
  endfunction

  function automatic logic x_clk_en();
    return (m != M_GATED) || ten;
  endfunction
  function automatic logic x_ready();
    return m == M_RUN;
  endfunction
  function automatic logic x_req();
    return m == M_REQ || m == M_GATED;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic go_gated();
    en = 1; busy = 0; wake = 0; ack = 0;
    for (int i = 0; i < IDLE + 2 && m != M_REQ; i++) tick();
    ack = 1;
    tick();
    ack = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (clk_en !== 1'b1 || ready !== 1'b1 || req !== 1'b0) begin
      errs++;
      $display("FAIL reset: en=%b rdy=%b req=%b need 1 1 0",
               clk_en, ready, req);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_idle_entry();
    en = 1; busy = 0; wake = 0; ack = 0;
    for (int i = 1; i <= IDLE; i++) begin
      tick();
      if (i >= IDLE - 1) begin
        checks++;
        if (req !== (i == IDLE) || ready !== (i != IDLE)) begin
          errs++;
          $display("FAIL idle_entry edge %0d: req=%b rdy=%b", i, req, ready);
        end
      end
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (clk_en !== 1'b0 || req !== 1'b1) begin
      errs++;
      $display("FAIL idle_gate: en=%b req=%b need 0 1", clk_en, req);
    end
    wake = 1;
    tick();
    wake = 0;
    repeat (WAKE) tick();
    checks++;
    if (ready !== 1'b1 || clk_en !== 1'b1) begin
      errs++;
      $display("FAIL idle_return: rdy=%b en=%b need 1 1", ready, clk_en);
    end
    en = 0;
    tick();
  endtask

  task automatic test_idle_restart();
    en = 1;
    repeat (10) tick();
    busy = 1;
    tick();
    busy = 0;
    for (int i = 1; i <= IDLE; i++) begin
      tick();
      checks++;
      if (req !== (i == IDLE) || req !== x_req()) begin
        errs++;
        $display("FAIL idle_restart edge %0d: req=%b need %b",
                 i, req, i == IDLE);
      end
    end
  endtask

  task automatic test_abort_priority();
    wake = 1;
    ack = 1;
    tick();
    wake = 0;
    ack = 0;
    checks++;
    if (clk_en !== 1'b1 || req !== 1'b0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL abort_prio: en=%b req=%b rdy=%b need 1 0 1",
               clk_en, req, ready);
    end
    en = 0;
    tick();
  endtask

  task automatic test_wake();
    go_gated();
    wake = 1;
    tick();
    wake = 0;
    checks++;
    if (clk_en !== 1'b1 || req !== 1'b0 || ready !== 1'b0) begin
      errs++;
      $display("FAIL wake_edge: en=%b req=%b rdy=%b need 1 0 0",
               clk_en, req, ready);
    end
    for (int i = 1; i <= WAKE; i++) begin
      tick();
      checks++;
      if (ready !== (i == WAKE)) begin
        errs++;
        $display("FAIL wake_ready %0d: rdy=%b need %b", i, ready, i == WAKE);
      end
    end
    en = 0;
    tick();
  endtask

  task automatic test_reset_test_en();
    go_gated();
    #2 ten = 1;
    #1;
    checks++;
    if (clk_en !== 1'b1 || req !== 1'b1 || ready !== 1'b0) begin
      errs++;
      $display("FAIL test_en: en=%b req=%b rdy=%b need 1 1 0",
               clk_en, req, ready);
    end
    ten = 0;
    #1;
    checks++;
    if (clk_en !== 1'b0) begin
      errs++;
      $display("FAIL test_en_off: en=%b need 0", clk_en);
    end
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (clk_en !== 1'b1 || ready !== 1'b1 || req !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: en=%b rdy=%b req=%b need 1 1 0",
               clk_en, ready, req);
    end
    @(negedge clk);
    rst_n = 1;
    en = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 19) != 0);
      busy = ($urandom_range(0, 39) == 0);
      wake = ($urandom_range(0, 49) == 0);
      ack  = $urandom_range(0, 1);
      ten  = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      tick();
      checks++;
      if (clk_en !== x_clk_en() || ready !== x_ready() || req !== x_req()) begin
        errs++;
        $display("FAIL random %0d: en=%b rdy=%b req=%b need %b %b %b",
                 i, clk_en, ready, req, x_clk_en(), x_ready(), x_req());
      end
`ifdef CLK_GATE_CTRL_STATS_EN
      checks++;
      if (gc !== SW'(gcount)) begin
        errs++;
        $display("FAIL random_stats %0d: got %0d need %0d", i, gc, gcount);
      end
`endif
    end
    ten = 0;
    clr = 0;
    en = 0;
    busy = 0;
    wake = 0;
    ack = 0;
    repeat (WAKE + 2) tick();
  endtask

`ifdef CLK_GATE_CTRL_STATS_EN
  task automatic test_stats();
    clr = 1;
    tick();
    clr = 0;
    go_gated();
    repeat (20) tick();
    checks++;
    if (gc !== 4'd15 || gc !== SW'(gcount)) begin
      errs++;
      $display("FAIL stats_sat: got %0d need 15", gc);
    end
    clr = 1;
    tick();
    clr = 0;
    checks++;
    if (gc !== 4'd0) begin
      errs++;
      $display("FAIL stats_clr: got %0d need 0", gc);
    end
    en = 0;
    repeat (WAKE + 2) tick();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_idle_entry();
    test_idle_restart();
    test_abort_priority();
    test_wake();
    test_reset_test_en();
    test_random();
`ifdef CLK_GATE_CTRL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
